// File: rtl/rrarb_req_queue.sv
// Per-requester FIFOs that feed the round-robin arbiter. Each valid one-hot grant
// pops the granted FIFO, and the entry appears one cycle later on a registered output.
module rrarb_req_queue #(
  parameter int unsigned nReq  = 16,
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned IdW  = (nReq > 1) ? $clog2(nReq) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [nReq-1:0]       push_valid,
  output logic [nReq-1:0]       push_ready,
  input  logic [nReq*DataW-1:0] push_data,
  output logic                  trigger,
  output logic [nReq-1:0]       request,
  input  logic [nReq-1:0]       grant,
  output logic                  out_valid,
  output logic [IdW-1:0]        out_id,
  output logic [DataW-1:0]      out_data,
  output logic                  grant_err
);

  logic [DataW-1:0] r_mem  [nReq][Depth];
  logic [PtrW-1:0]  r_wptr [nReq];
  logic [PtrW-1:0]  r_rptr [nReq];
  logic [CntW-1:0]  r_cnt  [nReq];

  logic [nReq-1:0]  w_push;
  logic [nReq-1:0]  w_pop;
  logic             w_onehot;
  logic             w_grant_ok;
  logic [IdW-1:0]   w_gnt_idx;
  logic [DataW-1:0] w_head;

  // Explicit wrap so any Depth works, not just powers of two.
  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < nReq; i++) begin
      request[i]    = (r_cnt[i] != '0);
      push_ready[i] = reset && (r_cnt[i] != CntW'(Depth));
    end
  end

  assign trigger    = |request;
  assign w_onehot   = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
  assign w_grant_ok = w_onehot && ((grant & request) != '0);
  assign w_push     = push_valid & push_ready;
  assign w_pop      = w_grant_ok ? grant : '0;

  always_comb begin
    w_gnt_idx = '0;
    w_head    = '0;
    for (int unsigned i = 0; i < nReq; i++) begin
      if (grant[i]) begin
        w_gnt_idx = IdW'(i);
        w_head    = r_mem[i][r_rptr[i]];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < nReq; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < nReq; i++) begin
        if (w_push[i]) r_wptr[i] <= f_inc(r_wptr[i]);
        if (w_pop[i])  r_rptr[i] <= f_inc(r_rptr[i]);
        if (w_push[i] && !w_pop[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_pop[i])
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < nReq; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= push_data[i*DataW +: DataW];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      grant_err <= 1'b0;
    end else begin
      out_valid <= w_grant_ok;
      if (w_grant_ok) begin
        out_id   <= w_gnt_idx;
        out_data <= w_head;
      end
      if ((grant != '0) && !w_grant_ok) grant_err <= 1'b1;
    end
  end

endmodule

// File: doc/rrarb_req_queue.md
Name: rrarb_req_queue

Overview:
- Upstream feeder for the round-robin arbiter (rrarbiter).
- Holds a per-requester FIFO of pending transactions, drives the arbiter's request vector and trigger, and consumes its one-hot grant.
- On each valid grant it pops the granted requester's head entry and emits it on a single registered output port, tagged with the requester index.

Parameters:
- nReq, 16, number of requesters; matches the arbiter's nReq.
- DataW, 32, payload width per transaction.
- Depth, 4, entries per requester FIFO; any integer ≥1, need not be a power of two.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (low = in reset).
- push_valid  input  nReq  per-requester push strobe.
- push_ready  output  nReq  per-requester FIFO has space.
- push_data  input  nReq*DataW  payloads; requester i occupies bits [i*DataW +: DataW].
- trigger  output  1  to arbiter; high when any request is pending.
- request  output  nReq  to arbiter; bit i high when FIFO i is non-empty.
- grant  input  nReq  from arbiter; one-hot or zero.
- out_valid  output  1  one-cycle pulse: popped entry is present.
- out_id  output  $clog2(nReq)  index of the popped requester.
- out_data  output  DataW  popped payload.
- grant_err  output  1  sticky protocol-error flag.

Behaviour:
- Per requester i: storage of Depth x DataW, write pointer, read pointer, and count of width $clog2(Depth+1). Pointers wrap from Depth-1 to 0 explicitly, with no reliance on power-of-two wrap.
- request[i] = (count[i] != 0), decoded from registers only (no combinational path from push or grant).
- trigger = |request.
- push_ready[i] = (count[i] != Depth) and reset deasserted. There is no full-bypass: a pop in the same cycle does not raise push_ready.
- Push accepted when push_valid[i] && push_ready[i]: write at wptr, advance wptr, count+1.
- Grant valid when grant is exactly one-hot, grant[k] == 1, and request[k] == 1.
  - A valid grant pops FIFO k that edge: advance rptr, count-1.
  - Next cycle: out_valid=1, out_id=k, out_data=old head of FIFO k (latency 1, registered).
- Grant invalid when it is multi-hot, or one-hot to an empty FIFO.
  - No pop, out_valid=0.
  - grant_err sets to 1 and holds until reset.
  - grant == 0 is legal idle, not an error.
- Push and pop on the same FIFO in the same cycle: both take effect and count is unchanged. Legal whenever count ≥1; when count == Depth, push_ready is low so no push occurs.
- Pushes to other FIFOs proceed independently of, and concurrently with, a pop.
- out_valid is a pulse. There is no downstream backpressure: the consumer must accept one entry per cycle.
- out_id and out_data hold their last value when out_valid=0.
- Reset (asynchronous assert, synchronous-safe release):
  - All counts, pointers, out_valid, out_id, out_data and grant_err go to 0.
  - Therefore request=0, trigger=0, push_ready=0 while reset is low, and push_ready=all-ones on the first cycle after release.
  - Asserting reset mid-operation discards all queued entries; no partial output is produced.
- FIFO storage contents need no reset.

Test Plan (nReq=4, DataW=8, Depth=4):
- Reset release, no stimulus -> request=4'b0000, trigger=0, push_ready=4'b1111, out_valid=0, grant_err=0.
- Push 0xA1 to requester 2, then grant=4'b0100 -> request=4'b0100 the cycle after the push; one cycle after the grant: out_valid=1, out_id=2, out_data=0xA1; then request=0, trigger=0.
- Push 0x10..0x13 to requester 0 -> push_ready[0]=0 after the 4th push; a 5th push is ignored. Four grants of 4'b0001 -> out_data 0x10,0x11,0x12,0x13 in order, with pointer wrap verified by a further push of 0x14 and its pop.
- Requester 1 holds count=2; same cycle: push 0x55 and grant=4'b0010 -> count stays 2, oldest entry is output, and 0x55 pops last.
- grant=4'b0011 with both FIFOs non-empty, or grant=4'b1000 with FIFO 3 empty -> no pop, out_valid=0, grant_err=1 and it stays 1 until reset.
- All four FIFOs loaded, then reset driven low mid-stream -> outputs are 0 immediately (asynchronous); after release request=0 and no stale entry is ever output.
